w4823_fir_coef_loader: RTL and testbench
========================================

// Module: w4823_fir_coef_loader
// PURPOSE
//  Upstream feeder for the W4823 FIR coefficient port.
//  - Accepts a byte-serial coefficient stream over a valid/ready handshake.
//  - Assembles 17-bit coefficients and writes them to the FIR as cin/caddr/cload, addresses 0..NTAPS-1.
//  - Sits between the host byte link and the FIR coefficient memory; runs on the fast clock.
// PARAMETERS
//  NTAPS  64  number of coefficients per load (address wraps never; load ends at NTAPS-1)
//  AW     6   coefficient address width, 2**AW >= NTAPS
//  CW     17  coefficient width (FP16 + 1 extension bit)
// PORTS
//  clk2     in   1   fast clock; all logic on posedge
//  rst_n    in   1   asynchronous active-low reset
//  start    in   1   1-cycle pulse: begin a load at address 0 (honoured in IDLE only)
//  abort    in   1   cancel a load in progress
//  s_data   in   8   stream byte
//  s_valid  in   1   s_data valid
//  s_ready  out  1   loader accepts byte; transfer = s_valid & s_ready
//  cin      out  CW  coefficient to FIR
//  caddr    out  AW  coefficient address to FIR
//  cload    out  1   1-cycle coefficient write strobe to FIR
//  busy     out  1   load in progress (state != IDLE)
//  done     out  1   1-cycle pulse at end of load
//  err      out  1   sticky error; cleared by next accepted start
// BEHAVIOUR
//  - Reset: state=IDLE; s_ready=0, cin=0, caddr=0, cload=0, busy=0, done=0, err=0. Reset mid-load drops
//    the partial coefficient; no cload is issued.
//  - Byte order per coefficient, 3 bytes little-endian:
//    - b0 -> cin[7:0]; b1 -> cin[15:8]; b2[0] -> cin[16].
//    - b2[7:1] must be 0.
//  - FSM states IDLE, B0, B1, B2, WR, [CK], DONE, ERR.
//    - IDLE: start -> B0; caddr<=0, err<=0.
//    - B0/B1/B2: s_ready=1. Each transfer latches its byte and advances B0->B1->B2->WR.
//      - If b2[7:1]!=0: go to ERR instead of WR.
//    - WR: cload=1 for exactly 1 cycle; cin/caddr stable while cload=1.
//      - caddr==NTAPS-1 -> CK (macro on) or DONE; else caddr<=caddr+1, go to B0.
//    - DONE: done=1 for 1 cycle -> IDLE. caddr holds its last value.
//    - ERR: err<=1, done=1 for 1 cycle -> IDLE.
//  - Latency: cload is high the cycle after the b2 transfer. Minimum 4 cycles per coefficient.
//    Full load >= 4*NTAPS + 2 cycles after start.
//  - s_valid low stalls in B0/B1/B2 indefinitely; no timeout.
//  - start while busy: ignored. start and abort in the same IDLE cycle: abort wins, stay IDLE.
//  - abort in any non-IDLE state: IDLE next cycle.
//    - cload, done and err are not asserted. If cload was already high in WR, that write stands.
//  - s_ready is 0 in IDLE, WR, CK (macro off), DONE and ERR. Bytes offered there are not consumed.
// CONFIGURATION
//  FIR_COEF_CKSUM_EN defined:
//    - After the last WR, state CK with s_ready=1 takes 1 checksum byte.
//    - Expected value = 8-bit modulo-256 sum of all 3*NTAPS data bytes. The running sum is cleared on start.
//    - Match -> DONE. Mismatch -> ERR.
//    - All coefficients are already written either way; err flags the table as suspect.
//  Undefined: no CK state, no sum register; err only from bad b2[7:1].
// TESTING
//  T1 reset: rst_n low mid-B1 -> all outputs 0 next cycle, no cload; after release, idle with s_ready=0.
//  T2 full load: start, 192 bytes back-to-back encoding coef[i]=i*0x0101 -> 64 cload pulses, caddr 0..63,
//     cin matches each value, single done, err=0.
//  T3 stall: drop s_valid for 5 cycles between b1 and b2 of coef 10 -> s_ready held 1, no cload until b2,
//     cin=0x0_0A0A written at caddr=10.
//  T4 format error: coef 3 b2=0x02 -> no cload for addr 3, err=1, done pulse, busy=0; next start clears err.
//  T5 abort/start: abort during B1 of coef 20 -> IDLE next cycle, no done/err; start while busy ignored.
//  T6 checksum (FIR_COEF_CKSUM_EN): correct sum byte -> done, err=0; sum^0x01 -> done, err=1, 64 cloads seen.

Source files
------------

// File: rtl/w4823_fir_coef_loader.sv
// W4823 FIR coefficient loader: byte stream -> 17-bit cin/caddr/cload writes.
// Optional trailing checksum byte when FIR_COEF_CKSUM_EN is defined.
module w4823_fir_coef_loader #(
    parameter int NTAPS = 64,
    parameter int AW    = 6,
    parameter int CW    = 17
) (
    input  logic          clk2,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [7:0]    s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [CW-1:0] cin,
    output logic [AW-1:0] caddr,
    output logic          cload,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        IDLE, B0, B1, B2, WR, CK, DONE, ERR
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);

    state_t state, state_nxt;
    logic   xfer;
    logic   last;
    logic   go;

    assign xfer = s_valid & s_ready;
    assign last = (caddr == LAST);
    assign go   = (state == IDLE) & start & ~abort;
    assign busy = (state != IDLE);

`ifdef FIR_COEF_CKSUM_EN
    logic [7:0] sum;
`endif

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        cload     = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: if (go) state_nxt = B0;
            B0: begin
                s_ready = 1'b1;
                if (xfer) state_nxt = B1;
            end
            B1: begin
                s_ready = 1'b1;
                if (xfer) state_nxt = B2;
            end
            B2: begin
                s_ready = 1'b1;
                if (xfer) state_nxt = (s_data[7:1] != 7'd0) ? ERR : WR;
            end
            WR: begin
                cload = 1'b1;
`ifdef FIR_COEF_CKSUM_EN
                state_nxt = last ? CK : B0;
`else
                state_nxt = last ? DONE : B0;
`endif
            end
            CK: begin
`ifdef FIR_COEF_CKSUM_EN
                s_ready = 1'b1;
                if (xfer) state_nxt = (s_data == sum) ? DONE : ERR;
`else
                state_nxt = IDLE;
`endif
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            ERR: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
        endcase
        // A write already strobed in WR stands; abort only suppresses done.
        if (abort && state != IDLE) begin
            state_nxt = IDLE;
            done      = 1'b0;
        end
    end

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            cin   <= '0;
            caddr <= '0;
            err   <= 1'b0;
        end else begin
            if (go) begin
                caddr <= '0;
                err   <= 1'b0;
            end
            if (xfer && state == B0) cin[7:0]  <= s_data;
            if (xfer && state == B1) cin[15:8] <= s_data;
            if (xfer && state == B2) cin[16]   <= s_data[0];
            if (state == WR && !last && !abort) caddr <= caddr + 1'b1;
            if (state == ERR && !abort) err <= 1'b1;
        end
    end

`ifdef FIR_COEF_CKSUM_EN
    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            sum <= 8'd0;
        end else if (go) begin
            sum <= 8'd0;
        end else if (xfer && (state == B0 || state == B1 || state == B2)) begin
            sum <= sum + s_data;
        end
    end
`endif

endmodule

// File: tb/tb_w4823_fir_coef_loader.sv
// Bench for w4823_fir_coef_loader: coefficient tables, scoreboard of expected
// writes, plus reset, stall, format-error, abort and checksum sequences.
`timescale 1ns/1ps
module tb_w4823_fir_coef_loader;
    localparam int NTAPS = 64;

    logic        clk2 = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  s_data = 8'd0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [16:0] cin;
    logic [5:0]  caddr;
    logic        cload;
    logic        busy;
    logic        done;
    logic        err;

    w4823_fir_coef_loader #(.NTAPS(NTAPS), .AW(6), .CW(17)) dut (
        .clk2(clk2), .rst_n(rst_n), .start(start), .abort(abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .cin(cin), .caddr(caddr), .cload(cload),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk2 = ~clk2;

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [16:0] cin;
    } vec_t;

    typedef struct {
        logic [5:0]  addr;
        logic [16:0] cin;
    } exp_t;

    vec_t tbl[NTAPS];
    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   ncload = 0;
    int   ndone = 0;
    logic [7:0] csum;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    always @(negedge clk2) begin
        if (cload === 1'b1) begin
            ncload++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL cload_unexpected: got cload=1 at caddr=%0d want 0", caddr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("cload_addr", 32'(caddr), 32'(e.addr));
                check("cload_cin", 32'(cin), 32'(e.cin));
            end
        end
        if (done === 1'b1) ndone++;
    end

    task automatic tick();
        @(posedge clk2);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        s_data  = b;
        s_valid = 1'b1;
        for (int k = 0; k <= 50; k++) begin
            if (k == 50) begin
                n_cmp++;
                n_fail++;
                $display("FAIL send_timeout: got s_ready=0 want 1");
                break;
            end
            @(negedge clk2);
            if (s_ready === 1'b1) begin
                tick();
                break;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic push_exp(input int i);
        exp_t e;
        e.addr = 6'(i);
        e.cin  = tbl[i].cin;
        exp_q.push_back(e);
    endtask

    task automatic send_coef(input int i, input logic [7:0] b2, input bit stall);
        send_byte(tbl[i].b0);
        send_byte(tbl[i].b1);
        if (stall) begin
            repeat (5) begin
                @(negedge clk2);
                check("stall_ready", 32'(s_ready), 1);
                check("stall_cload", 32'(cload), 0);
                tick();
            end
        end
        if (b2[7:1] == 7'd0) push_exp(i);
        send_byte(b2);
        csum = csum + tbl[i].b0 + tbl[i].b1 + b2;
        if (b2[7:1] == 7'd0) check("cload_latency", 32'(cload), 1);
    endtask

    task automatic wait_done(input int d0);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk2);
            #1;
            if (ndone > d0) break;
        end
        tick();
        check("done_pulses", 32'(ndone - d0), 1);
    endtask

    task automatic run_load(input int stall_at, input int err_at, input logic [7:0] ck_flip);
        int   c0;
        int   d0;
        logic exp_err;
        c0 = ncload;
        d0 = ndone;
        csum = 8'd0;
        exp_err = (err_at >= 0);
        pulse_start();
        check("busy_after_start", 32'(busy), 1);
        check("err_cleared_by_start", 32'(err), 0);
        for (int i = 0; i < NTAPS; i++) begin
            if (i == err_at) begin
                send_coef(i, 8'h02, 1'b0);
                break;
            end
            send_coef(i, tbl[i].b2, i == stall_at);
        end
`ifdef FIR_COEF_CKSUM_EN
        if (err_at < 0) send_byte(csum ^ ck_flip);
        if (ck_flip != 8'd0) exp_err = 1'b1;
`endif
        wait_done(d0);
        check("cload_count", 32'(ncload - c0), err_at < 0 ? NTAPS : err_at);
        check("queue_empty", 32'(exp_q.size()), 0);
        check("err_flag", 32'(err), 32'(exp_err));
        check("busy_end", 32'(busy), 0);
        tick();
        check("single_done", 32'(ndone - d0), 1);
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < NTAPS; i++) begin
            tbl[i].cin = 17'(i * 'h0101);
            tbl[i].b0  = tbl[i].cin[7:0];
            tbl[i].b1  = tbl[i].cin[15:8];
            tbl[i].b2  = {7'd0, tbl[i].cin[16]};
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < NTAPS; i++) begin
            tbl[i].cin = 17'($urandom);
            tbl[i].b0  = tbl[i].cin[7:0];
            tbl[i].b1  = tbl[i].cin[15:8];
            tbl[i].b2  = {7'd0, tbl[i].cin[16]};
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_s_ready"}, 32'(s_ready), 0);
        check({tag, "_cin"}, 32'(cin), 0);
        check({tag, "_caddr"}, 32'(caddr), 0);
        check({tag, "_cload"}, 32'(cload), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_err"}, 32'(err), 0);
    endtask

    initial begin
        int c0;
        int d0;
        fill_ramp();
        repeat (3) tick();
        check_quiet("reset");
        rst_n = 1'b1;
        tick();

        // T1: reset in the middle of B1
        c0 = ncload;
        pulse_start();
        send_byte(8'hA5);
        check("t1_in_b1", 32'(s_ready), 1);
        rst_n = 1'b0;
        #1;
        check_quiet("t1_rst");
        tick();
        check("t1_no_cload", 32'(ncload - c0), 0);
        rst_n = 1'b1;
        tick();
        s_valid = 1'b1;
        @(negedge clk2);
        check("t1_idle_ready", 32'(s_ready), 0);
        check("t1_idle_busy", 32'(busy), 0);
        tick();
        s_valid = 1'b0;

        // T2: full ramp load
        run_load(-1, -1, 8'h00);
        check("t2_caddr_hold", 32'(caddr), NTAPS - 1);

        // T3: stall between b1 and b2 of coef 10
        run_load(10, -1, 8'h00);

        // T4: format error on coef 3
        run_load(-1, 3, 8'h00);

        // Random table; its start also clears the T4 error
        fill_random();
        run_load(-1, -1, 8'h00);

        // T5: start while busy ignored, abort during B1 of coef 20
        fill_ramp();
        c0 = ncload;
        d0 = ndone;
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                pulse_start();
                check("t5_start_ignored", 32'(caddr), 5);
            end
            send_coef(i, tbl[i].b2, 1'b0);
        end
        send_byte(tbl[20].b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_abort_idle", 32'(busy), 0);
        repeat (3) tick();
        check("t5_no_done", 32'(ndone - d0), 0);
        check("t5_no_err", 32'(err), 0);
        check("t5_cloads", 32'(ncload - c0), 20);
        check("t5_queue", 32'(exp_q.size()), 0);

        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("t5_abort_wins", 32'(busy), 0);

`ifdef FIR_COEF_CKSUM_EN
        // T6: good checksum, then corrupted checksum
        run_load(-1, -1, 8'h00);
        run_load(-1, -1, 8'h01);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
